// File: rtl/hbm_mvm_wt_fetch_sched.sv
// hbm_mvm_wt_fetch_sched
//   Issues the HBM scale/weight read stream for one MVM job. Outer loop walks
//   CHout tiles, inner loop walks CHin quantisation groups; every group is one
//   scale-word read followed by one weight-block read. In-flight requests are
//   capped at MAX_OUTSTANDING.
// Ports
//   clk, rst_n            clock, async active-low reset
//   start, cfg_*          job launch pulse and job configuration (latched on start)
//   req_*                 read request to the HBM read engine (valid/ready)
//   rsp_done              one pulse per completed request
//   busy, done            job active, one-cycle end-of-job pulse
module hbm_mvm_wt_fetch_sched #(
   parameter int ADDR_W          = 32,
   parameter int LEN_W           = 24,
   parameter int CNT_W           = 16,
   parameter int GRP_BYTES       = 1024,
   parameter int SCALE_BYTES     = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [ADDR_W-1:0] cfg_tile_stride,
   input  logic [CNT_W-1:0]  cfg_chout_tiles,
   input  logic [CNT_W-1:0]  cfg_groups,
   input  logic [LEN_W-1:0]  cfg_last_grp_bytes,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   output logic [LEN_W-1:0]  req_bytes,
   output logic              req_is_scale,
   output logic [CNT_W-1:0]  req_tile,
   output logic [CNT_W-1:0]  req_group,
   output logic              req_last,
   input  logic              rsp_done,
   output logic              busy,
   output logic              done
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SCALE, S_WT, S_DRAIN, S_DONE
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] stride_q;
   logic [CNT_W-1:0]  tiles_q;
   logic [CNT_W-1:0]  groups_q;
   logic [LEN_W-1:0]  lastb_q;
   logic [ADDR_W-1:0] tile_base_q;   // base + t*stride, accumulated per tile
   logic [ADDR_W-1:0] ptr_q;         // byte pointer inside current tile
   logic [CNT_W-1:0]  tile_q;
   logic [CNT_W-1:0]  grp_q;
   logic [OW-1:0]     outst_q;
   logic [OW-1:0]     outst_d;
   logic              busy_q;
   logic              done_q;

   logic              last_grp;
   logic              last_tile;
   logic [LEN_W-1:0]  wt_bytes;
   logic              hs;
   logic              rsp_ok;
   logic              in_req;

   assign last_grp  = (grp_q == groups_q - CNT_W'(1));
   assign last_tile = (tile_q == tiles_q - CNT_W'(1));
   assign wt_bytes  = (last_grp && lastb_q != '0) ? lastb_q : LEN_W'(GRP_BYTES);
   assign in_req    = (state_q == S_SCALE) || (state_q == S_WT);

   // Valid depends only on registered state, so once raised it cannot drop
   // before the handshake: the outstanding count can only fall meanwhile.
   assign req_valid    = in_req && (outst_q < OW'(MAX_OUTSTANDING));
   assign hs           = req_valid && req_ready;
   assign rsp_ok       = rsp_done && (outst_q != '0);
   assign req_addr     = ptr_q;
   assign req_is_scale = (state_q == S_SCALE);
   assign req_tile     = tile_q;
   assign req_group    = grp_q;
   assign req_last     = (state_q == S_WT) && last_grp && last_tile;
   assign busy         = busy_q;
   assign done         = done_q;

   always_comb begin
      req_bytes = '0;
      if (state_q == S_SCALE)   req_bytes = LEN_W'(SCALE_BYTES);
      else if (state_q == S_WT) req_bytes = wt_bytes;
   end

   always_comb begin
      outst_d = outst_q;
      case ({hs, rsp_ok})
         2'b10:   outst_d = outst_q + OW'(1);
         2'b01:   outst_d = outst_q - OW'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         stride_q    <= '0;
         tiles_q     <= '0;
         groups_q    <= '0;
         lastb_q     <= '0;
         tile_base_q <= '0;
         ptr_q       <= '0;
         tile_q      <= '0;
         grp_q       <= '0;
         outst_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         outst_q <= outst_d;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // done_q high means this is the DONE cycle: start is ignored
               if (start && !done_q) begin
                  stride_q    <= cfg_tile_stride;
                  tiles_q     <= cfg_chout_tiles;
                  groups_q    <= cfg_groups;
                  lastb_q     <= cfg_last_grp_bytes;
                  tile_base_q <= cfg_base_addr;
                  ptr_q       <= cfg_base_addr;
                  tile_q      <= '0;
                  grp_q       <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= (cfg_chout_tiles == '0 || cfg_groups == '0) ? S_DONE : S_SCALE;
               end
            end
            S_SCALE: begin
               if (hs) begin
                  ptr_q   <= ptr_q + ADDR_W'(SCALE_BYTES);
                  state_q <= S_WT;
               end
            end
            S_WT: begin
               if (hs) begin
                  if (!last_grp) begin
                     grp_q   <= grp_q + CNT_W'(1);
                     ptr_q   <= ptr_q + ADDR_W'(wt_bytes);
                     state_q <= S_SCALE;
                  end else if (!last_tile) begin
                     tile_q      <= tile_q + CNT_W'(1);
                     grp_q       <= '0;
                     tile_base_q <= tile_base_q + stride_q;
                     ptr_q       <= tile_base_q + stride_q;
                     state_q     <= S_SCALE;
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (outst_d == '0) state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hbm_mvm_wt_fetch_sched.sv
// Directed bench for hbm_mvm_wt_fetch_sched: expected request tables plus
// hand-written sequences for the cap, backpressure, degenerate and reset cases.
module tb_hbm_mvm_wt_fetch_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cfg_base_addr = '0;
   logic [31:0] cfg_tile_stride = '0;
   logic [15:0] cfg_chout_tiles = '0;
   logic [15:0] cfg_groups = '0;
   logic [23:0] cfg_last_grp_bytes = '0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] req_addr;
   logic [23:0] req_bytes;
   logic        req_is_scale;
   logic [15:0] req_tile;
   logic [15:0] req_group;
   logic        req_last;
   logic        rsp_done = 1'b0;
   logic        busy;
   logic        done;

   hbm_mvm_wt_fetch_sched dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_base_addr(cfg_base_addr), .cfg_tile_stride(cfg_tile_stride),
      .cfg_chout_tiles(cfg_chout_tiles), .cfg_groups(cfg_groups),
      .cfg_last_grp_bytes(cfg_last_grp_bytes),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_bytes(req_bytes), .req_is_scale(req_is_scale), .req_tile(req_tile),
      .req_group(req_group), .req_last(req_last), .rsp_done(rsp_done),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [23:0] b;
      logic        l;
      logic [15:0] t;
      logic [15:0] g;
   } req_t;

   function automatic req_t mk(logic s, logic [31:0] a, logic [23:0] b,
                               logic l, logic [15:0] t, logic [15:0] g);
      req_t r;
      r.s = s; r.a = a; r.b = b; r.l = l; r.t = t; r.g = g;
      return r;
   endfunction

   function automatic logic [95:0] pk(req_t r);
      return {6'd0, r.s, r.a, r.b, r.l, r.t, r.g};
   endfunction

   int   checks = 0;
   int   fails = 0;
   int   ncyc = 0;
   int   done_cnt = 0;
   int   done_ncyc = 0;
   int   last_rsp_ncyc = 0;
   int   valid_cnt = 0;
   int   extra_rsp = 0;
   bit   rsp_en = 1'b0;
   int   pend[$];
   req_t log_q[$];

   // Monitor + completion model, evaluated on the falling edge
   initial forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
         pend.delete();
         rsp_done = 1'b0;
      end else begin
         if (req_valid) valid_cnt++;
         if (req_valid && req_ready) begin
            log_q.push_back(mk(req_is_scale, req_addr, req_bytes, req_last, req_tile, req_group));
            if (rsp_en) pend.push_back(ncyc + 3);
         end
         if (done) begin
            done_cnt++;
            done_ncyc = ncyc;
         end
         rsp_done = 1'b0;
         if (pend.size() > 0 && pend[0] == ncyc) begin
            rsp_done = 1'b1;
            void'(pend.pop_front());
         end
         if (extra_rsp > 0) begin
            rsp_done = 1'b1;
            extra_rsp--;
         end
         if (rsp_done) last_rsp_ncyc = ncyc;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      log_q.delete();
      done_cnt = 0;
      done_ncyc = 0;
      last_rsp_ncyc = 0;
      valid_cnt = 0;
   endtask

   task automatic start_job(logic [31:0] base, logic [31:0] stride,
                            logic [15:0] tiles, logic [15:0] groups, logic [23:0] lastb);
      cfg_base_addr      = base;
      cfg_tile_stride    = stride;
      cfg_chout_tiles    = tiles;
      cfg_groups         = groups;
      cfg_last_grp_bytes = lastb;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(string nm, int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         tick(1);
         k++;
      end
      chk({nm, "_done_seen"}, 96'(done), 96'd1);
      tick(1);
   endtask

   task automatic check_log(string nm, input req_t e[$]);
      chk({nm, "_count"}, 96'(log_q.size()), 96'(e.size()));
      for (int i = 0; i < e.size(); i++)
         if (i < log_q.size())
            chk($sformatf("%s_req%0d", nm, i), pk(log_q[i]), pk(e[i]));
   endtask

   initial begin
      req_t tbl1[$];
      req_t tbl2[$];
      int   k;
      int   lat;
      logic busy_mid;

      // Expected request streams
      tbl1 = '{ mk(1, 32'h1000, 32,   0, 0, 0), mk(0, 32'h1020, 1024, 0, 0, 0),
                mk(1, 32'h1420, 32,   0, 0, 1), mk(0, 32'h1440, 1024, 0, 0, 1),
                mk(1, 32'h3000, 32,   0, 1, 0), mk(0, 32'h3020, 1024, 0, 1, 0),
                mk(1, 32'h3420, 32,   0, 1, 1), mk(0, 32'h3440, 1024, 1, 1, 1) };
      tbl2 = '{ mk(1, 32'h1000, 32,   0, 0, 0), mk(0, 32'h1020, 1024, 0, 0, 0),
                mk(1, 32'h1420, 32,   0, 0, 1), mk(0, 32'h1440, 1024, 0, 0, 1),
                mk(1, 32'h1840, 32,   0, 0, 2), mk(0, 32'h1860, 256,  1, 0, 2) };

      // Reset state
      tick(3);
      chk("reset_outputs",
          96'({req_valid, req_addr, req_bytes, req_is_scale, req_tile, req_group, req_last, busy, done}),
          96'd0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_after_reset", 96'({req_valid, busy, done}), 96'd0);

      // Job 1: 2 tiles x 2 groups, completions 3 cycles after each request
      req_ready = 1'b1;
      rsp_en = 1'b1;
      clear_log();
      start_job(32'h1000, 32'h2000, 16'd2, 16'd2, 24'd0);
      chk("job1_busy", 96'(busy), 96'd1);
      wait_done("job1", 200);
      tick(2);
      check_log("job1", tbl1);
      chk("job1_done_once", 96'(done_cnt), 96'd1);
      chk("job1_done_after_last_rsp", 96'(done_ncyc > last_rsp_ncyc), 96'd1);
      chk("job1_idle", 96'({busy, req_valid}), 96'd0);

      // Job 2: short last group
      clear_log();
      start_job(32'h1000, 32'h0, 16'd1, 16'd3, 24'd256);
      wait_done("job2", 200);
      tick(2);
      check_log("job2", tbl2);

      // Outstanding cap: no completions
      rsp_en = 1'b0;
      clear_log();
      start_job(32'h1000, 32'h0, 16'd1, 16'd4, 24'd0);
      tick(15);
      chk("cap_count", 96'(log_q.size()), 96'd4);
      chk("cap_held", 96'({req_valid, req_is_scale, req_addr, req_bytes, req_group}),
          96'({1'b0, 1'b1, 32'h1840, 24'd32, 16'd2}));
      tick(3);
      chk("cap_stable", 96'({req_valid, req_is_scale, req_addr, req_bytes, req_group}),
          96'({1'b0, 1'b1, 32'h1840, 24'd32, 16'd2}));
      extra_rsp = 1;
      tick(6);
      chk("cap_release_one", 96'(log_q.size()), 96'd5);
      chk("cap_valid_again_low", 96'(req_valid), 96'd0);
      if (log_q.size() > 4)
         chk("cap_released_req", pk(log_q[4]), pk(mk(1, 32'h1840, 32, 0, 0, 2)));
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Backpressure
      rsp_en = 1'b1;
      req_ready = 1'b0;
      clear_log();
      start_job(32'h8000, 32'h0, 16'd1, 16'd2, 24'd0);
      k = 0;
      while (!req_valid && k < 10) begin
         tick(1);
         k++;
      end
      chk("bp_valid_seen", 96'(req_valid), 96'd1);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk($sformatf("bp_hold%0d", i),
             96'({req_valid, req_is_scale, req_addr, req_bytes, req_tile, req_group}),
             96'({1'b1, 1'b1, 32'h8000, 24'd32, 16'd0, 16'd0}));
      end
      chk("bp_no_transfer", 96'(log_q.size()), 96'd0);
      req_ready = 1'b1;
      wait_done("bp", 200);
      tick(2);
      chk("bp_count", 96'(log_q.size()), 96'd4);
      if (log_q.size() == 4)
         chk("bp_last_req", pk(log_q[3]), pk(mk(0, 32'h8440, 1024, 1, 0, 1)));

      // Degenerate job; start held through busy and DONE cycles with a new cfg
      clear_log();
      cfg_base_addr   = 32'h100;
      cfg_chout_tiles = 16'd0;
      cfg_groups      = 16'd5;
      start = 1'b1;
      lat = 0;
      busy_mid = 1'b0;
      while (!done && lat < 10) begin
         tick(1);
         lat++;
         if (lat == 1) begin
            busy_mid = busy;
            cfg_chout_tiles = 16'd1;
            cfg_groups      = 16'd1;
         end
      end
      chk("degen_latency", 96'(lat), 96'd2);
      chk("degen_busy_mid", 96'(busy_mid), 96'd1);
      chk("degen_busy_drops_with_done", 96'(busy), 96'd0);
      tick(1);
      start = 1'b0;
      tick(6);
      chk("degen_no_valid", 96'(valid_cnt), 96'd0);
      chk("degen_done_once", 96'(done_cnt), 96'd1);
      chk("degen_idle", 96'(busy), 96'd0);

      // Reset in WT with 2 outstanding
      rsp_en = 1'b0;
      req_ready = 1'b1;
      clear_log();
      start_job(32'h1000, 32'h2000, 16'd2, 16'd2, 24'd0);
      k = 0;
      while (log_q.size() < 3 && k < 50) begin
         tick(1);
         k++;
      end
      req_ready = 1'b0;
      extra_rsp = 1;
      tick(3);
      chk("rst_pre_state", 96'({req_valid, req_is_scale, req_addr}),
          96'({1'b1, 1'b0, 32'h1440}));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_outputs_zero",
          96'({req_valid, req_addr, req_bytes, req_is_scale, req_tile, req_group, req_last, busy, done}),
          96'd0);
      tick(3);
      chk("rst_held_quiet", 96'({busy, done, req_valid}), 96'd0);
      rst_n = 1'b1;
      extra_rsp = 0;
      clear_log();
      tick(4);
      chk("rst_no_done", 96'(done_cnt), 96'd0);
      req_ready = 1'b1;
      rsp_en = 1'b1;
      clear_log();
      start_job(32'h1000, 32'h2000, 16'd2, 16'd2, 24'd0);
      wait_done("post_rst", 200);
      tick(2);
      check_log("post_rst", tbl1);
      chk("post_rst_done_once", 96'(done_cnt), 96'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/hbm_mvm_wt_fetch_sched.md
Name: hbm_mvm_wt_fetch_sched

Overview:
- Sequences HBM weight and scale reads for the HBM MVM datapath.
- On start, walks CHout tiles (outer loop) and CHin quantisation groups (inner loop). Each group issues one scale-word read followed by one weight-block read.
- Sits between the MVM run controller (config/start/done) and the HBM read engine (request/completion). Caps the number of in-flight requests.

Parameters:
- ADDR_W, 32, HBM byte address width
- LEN_W, 24, request byte-count width
- CNT_W, 16, tile/group counter width
- GRP_BYTES, 1024, weight bytes per full group (WT_CH_Tgroup*WT_DW/8)
- SCALE_BYTES, 32, scale bytes per group (HBM_AXI_DATA_WIDTH/8)
- MAX_OUTSTANDING, 4, maximum accepted-but-uncompleted requests

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse; latches cfg_*; ignored unless idle
- cfg_base_addr, in, ADDR_W, tile-0 base address
- cfg_tile_stride, in, ADDR_W, byte stride between CHout tiles
- cfg_chout_tiles, in, CNT_W, number of CHout tiles (CHout_div_Tout)
- cfg_groups, in, CNT_W, groups per tile (WT_scale_group_nums)
- cfg_last_grp_bytes, in, LEN_W, weight bytes of the last group; 0 means GRP_BYTES
- req_valid, out, 1, request valid
- req_ready, in, 1, read engine accepts
- req_addr, out, ADDR_W, byte address
- req_bytes, out, LEN_W, byte count
- req_is_scale, out, 1, 1 = scale read, 0 = weight read
- req_tile, out, CNT_W, current tile index
- req_group, out, CNT_W, current group index
- req_last, out, 1, final request of the job
- rsp_done, in, 1, one pulse per completed request
- busy, out, 1, job active
- done, out, 1, one-cycle pulse at job end

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Counters, pointers and outstanding count cleared. Reset mid-job aborts immediately with no done pulse.
- States: IDLE -> SCALE -> WT -> (SCALE of next group/tile | DRAIN) -> DONE -> IDLE.
- IDLE:
  - On start, latch cfg_* and set busy=1 on the next cycle.
  - If cfg_chout_tiles==0 or cfg_groups==0, go to DONE directly; no requests are issued.
- Address generation:
  - tile_ptr = cfg_base_addr + t*cfg_tile_stride, formed by an accumulator (no multiplier).
  - Within a tile, a byte pointer starts at tile_ptr.
  - SCALE request: addr = ptr, bytes = SCALE_BYTES; then ptr += SCALE_BYTES.
  - WT request: addr = ptr, bytes = (last group && cfg_last_grp_bytes!=0) ? cfg_last_grp_bytes : GRP_BYTES; then ptr += bytes.
  - Address arithmetic wraps modulo 2^ADDR_W.
- Handshake:
  - req_valid is asserted in SCALE/WT only when outstanding < MAX_OUTSTANDING.
  - Once req_valid is high, all req_* fields are held stable until req_valid && req_ready.
  - Transfer occurs in the cycle req_valid && req_ready. The next request may be valid in the following cycle, giving 1 request/cycle maximum.
- Outstanding counter:
  - +1 on handshake; -1 on rsp_done; unchanged when both occur in the same cycle.
  - rsp_done while the count is 0 is ignored.
- req_last = 1 on the WT request of the last group of the last tile.
- After that handshake, move to DRAIN. Wait until outstanding==0 (counting a same-cycle rsp_done), then DONE.
- DONE: done=1 for one cycle; busy drops in the same cycle; return to IDLE. A start in the DONE cycle is ignored.
- start while busy: ignored; configuration unchanged.
- Total requests per job = 2*tiles*groups.

Test Plan:
- Job size and addressing:
  - Stimulus: base=0x1000, stride=0x2000, tiles=2, groups=2, last=0, req_ready=1, rsp_done 3 cycles after each request.
  - Expected: 8 requests in order S@0x1000/32, W@0x1020/1024, S@0x1420/32, W@0x1440/1024, S@0x3000, W@0x3020, S@0x3420, W@0x3440. req_last only on the 8th request. done pulses once, after the 8th completion.
- Short last group:
  - Stimulus: groups=3, last_grp_bytes=256, tiles=1.
  - Expected: third W has bytes=256 at base+3*32+2*1024.
- Outstanding cap:
  - Stimulus: req_ready=1, rsp_done withheld.
  - Expected: exactly 4 handshakes, then req_valid=0 and fields stable. One rsp_done pulse releases exactly one more request.
- Backpressure:
  - Stimulus: req_ready low for 5 cycles while req_valid=1.
  - Expected: req_addr, req_bytes and req_is_scale are unchanged across all 5 cycles; no counter advance.
- Degenerate job:
  - Stimulus: tiles=0.
  - Expected: no req_valid; done 2 cycles after start; start during busy is ignored.
- Reset mid-job:
  - Stimulus: assert rst_n=0 during WT with 2 requests outstanding.
  - Expected: all outputs 0 immediately. No done pulse. A fresh start then runs a full correct job.
